// File: rtl/risc_pkg.sv
// Shared definitions for the instruction-memory loader: data widths and the loader FSM encoding.
package risc_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; `word` already includes the byte being
// strobed this cycle, so the fourth byte and the finished word are visible on the same edge.
module byte_word_packer
   import risc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            strobe,
   input  logic [7:0]      data,
   output logic            word_full,
   output logic [XLEN-1:0] word
);

   logic [1:0]      idx;
   logic [XLEN-1:0] word_q;

   always_comb begin
      word = word_q;
      if (strobe) begin
         case (idx)
            2'd0:    word[7:0]   = data;
            2'd1:    word[15:8]  = data;
            2'd2:    word[23:16] = data;
            default: word[31:24] = data;
         endcase
      end
   end

   assign word_full = strobe && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx    <= 2'd0;
         word_q <= '0;
      end else if (strobe) begin
         idx    <= idx + 2'd1;
         word_q <= word;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: receives bytes, packs words, writes them into the store and
// keeps the core in reset for the duration of the load.
module instr_mem_loader
   import risc_pkg::*;
#(
   parameter int MEM_BYTES = 128,
   parameter int LEN_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [31:0]      Base_Addr,
   input  logic [LEN_W-1:0] Num_Words,
   input  logic             Byte_Valid,
   input  logic [7:0]       Byte_Data,
   output logic             Byte_Ready,
   output logic             Mem_Wr_En,
   output logic [31:0]      Mem_Wr_Addr,
   output logic [31:0]      Mem_Wr_Data,
   output logic             Cpu_Hold,
   output logic             Busy,
   output logic             Done,
   output logic             Err,
   output logic [2:0]       dbg_state
);

   // Byte handshake: a byte moves on a rising edge only when Byte_Valid && Byte_Ready are both
   // high in the preceding cycle; the sender must hold Byte_Data stable until that happens.

   loader_state_t    state, next_state;
   logic [XLEN-1:0]  addr;
   logic [LEN_W-1:0] words_left;
   logic [XLEN-1:0]  base_aligned;
   logic [XLEN-1:0]  word;
   logic             word_full;
   logic             xfer;
   logic             start_ok;
   logic             fits;

   assign base_aligned = Base_Addr & ~32'd3;
   assign start_ok     = (state == IDLE) && Start;
   assign Byte_Ready   = (state == RECV);
   assign xfer         = Byte_Valid && Byte_Ready;
   assign Busy         = (state != IDLE);
   assign dbg_state    = state;

   // 33-bit sum so an address near 2**32 cannot wrap into a legal range.
   assign fits = ({1'b0, addr} + 33'(INSTR_BYTES)) <= 33'(MEM_BYTES);

   byte_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .strobe    (xfer),
      .data      (Byte_Data),
      .word_full (word_full),
      .word      (word)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Start) next_state = (Num_Words == '0) ? DONE : RECV;
         RECV:    if (word_full) next_state = WRITE;
         WRITE: begin
            if (!fits)                          next_state = ERR;
            else if (words_left == LEN_W'(1))   next_state = DONE;
            else                                next_state = RECV;
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = ERR;
         default: next_state = IDLE;
      endcase
   end

   // The write strobe and its address/data are loaded on the edge that takes the fourth byte,
   // so the strobe is visible exactly during the WRITE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr        <= '0;
         words_left  <= '0;
         Mem_Wr_En   <= 1'b0;
         Mem_Wr_Addr <= '0;
         Mem_Wr_Data <= '0;
         Cpu_Hold    <= 1'b0;
         Done        <= 1'b0;
         Err         <= 1'b0;
      end else begin
         Mem_Wr_En <= 1'b0;
         Done      <= (state == DONE);
         Cpu_Hold  <= (next_state != IDLE) || (state == DONE);
         if (start_ok) begin
            addr       <= base_aligned;
            words_left <= Num_Words;
            Err        <= 1'b0;
         end
         if ((state == RECV) && word_full && fits) begin
            Mem_Wr_En   <= 1'b1;
            Mem_Wr_Addr <= addr;
            Mem_Wr_Data <= word;
         end
         if (state == WRITE) begin
            if (fits) begin
               addr       <= addr + 32'(INSTR_BYTES);
               words_left <= words_left - LEN_W'(1);
            end else begin
               Err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a table of whole loads plus hand-written sequences for
// empty loads, overflow, reset mid-load and Start while busy.
module tb_instr_mem_loader;
   import risc_pkg::*;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        Start      = 1'b0;
   logic [31:0] Base_Addr  = '0;
   logic [5:0]  Num_Words  = '0;
   logic        Byte_Valid = 1'b0;
   logic [7:0]  Byte_Data  = '0;
   logic        Byte_Ready, Mem_Wr_En, Cpu_Hold, Busy, Done, Err;
   logic [31:0] Mem_Wr_Addr, Mem_Wr_Data;
   logic [2:0]  dbg_state;

   instr_mem_loader #(.MEM_BYTES(128), .LEN_W(6)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Base_Addr(Base_Addr), .Num_Words(Num_Words),
      .Byte_Valid(Byte_Valid), .Byte_Data(Byte_Data), .Byte_Ready(Byte_Ready),
      .Mem_Wr_En(Mem_Wr_En), .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data),
      .Cpu_Hold(Cpu_Hold), .Busy(Busy), .Done(Done), .Err(Err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int wr_count = 0;
   int first_wr_cyc = -1;
   logic [63:0] exp_q[$];

   always @(posedge clk) cyc++;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard: every observed write must match the head of the expected queue.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!reset && Mem_Wr_En) begin
         wr_count++;
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         check("ready_low_in_write", 32'(Byte_Ready), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h expected=none", Mem_Wr_Addr, Mem_Wr_Data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", Mem_Wr_Addr, e[63:32]);
            check("wr_data", Mem_Wr_Data, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic start_load(input logic [31:0] base, input logic [5:0] num);
      @(posedge clk); #1;
      Start = 1'b1; Base_Addr = base; Num_Words = num;
      start_cyc = cyc;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      Byte_Valid = 1'b1;
      Byte_Data  = b;
      @(negedge clk);
      while (!Byte_Ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!Byte_Ready) check("byte_accept_timeout", 32'(Byte_Ready), 32'd1);
      @(posedge clk); #1;
      Byte_Valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) begin
         if (gap) begin
            @(posedge clk); #1;
         end
         send_byte(t[7:0]);
         t = t >> 8;
      end
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (Done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   typedef struct {
      logic [31:0] base;
      logic [5:0]  num;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] a0;
      logic [31:0] a1;
      bit          gap;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int wr0;
      int hold_cnt;
      int done_off;
      logic [31:0] last_a;

      vecs[0] = '{32'h0000_0000, 6'd1, 32'h0050_0113, 32'h0,         32'h00, 32'h00, 1'b0};
      vecs[1] = '{32'h0000_0008, 6'd2, 32'h00C0_0193, 32'hFF71_8393, 32'h08, 32'h0C, 1'b1};
      vecs[2] = '{32'h0000_0006, 6'd1, 32'h1234_5678, 32'h0,         32'h04, 32'h00, 1'b0};
      vecs[3] = '{32'h0000_0040, 6'd2, 32'hDEAD_BEEF, 32'hA5A5_5A5A, 32'h40, 32'h44, 1'b0};
      vecs[4] = '{32'h0000_0078, 6'd2, 32'h0000_0001, 32'h8000_0000, 32'h78, 32'h7C, 1'b0};

      do_reset();
      @(negedge clk);
      check("rst_byte_ready", 32'(Byte_Ready), 32'd0);
      check("rst_wr_en",      32'(Mem_Wr_En),  32'd0);
      check("rst_wr_addr",    Mem_Wr_Addr,     32'd0);
      check("rst_wr_data",    Mem_Wr_Data,     32'd0);
      check("rst_cpu_hold",   32'(Cpu_Hold),   32'd0);
      check("rst_busy",       32'(Busy),       32'd0);
      check("rst_done",       32'(Done),       32'd0);
      check("rst_err",        32'(Err),        32'd0);
      check("rst_state",      32'(dbg_state),  32'(IDLE));

      for (int i = 0; i < 5; i++) begin
         wr0 = wr_count;
         first_wr_cyc = -1;
         exp_q.push_back({vecs[i].a0, vecs[i].w0});
         last_a = vecs[i].a0;
         if (vecs[i].num == 6'd2) begin
            exp_q.push_back({vecs[i].a1, vecs[i].w1});
            last_a = vecs[i].a1;
         end
         start_load(vecs[i].base, vecs[i].num);
         send_word(vecs[i].w0, vecs[i].gap);
         if (vecs[i].num == 6'd2) send_word(vecs[i].w1, vecs[i].gap);
         wait_done();
         check("vec_busy_at_done", 32'(Busy), 32'd0);
         check("vec_hold_at_done", 32'(Cpu_Hold), 32'd1);
         check("vec_writes", 32'(wr_count - wr0), 32'(vecs[i].num));
         check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
         check("vec_err", 32'(Err), 32'd0);
         if (!vecs[i].gap) check("first_wr_latency", 32'(first_wr_cyc - start_cyc), 32'd5);
         @(negedge clk);
         check("hold_released", 32'(Cpu_Hold), 32'd0);
         check("wr_addr_held", Mem_Wr_Addr, last_a);
      end

      // Empty load: Done two cycles after Start, hold for two cycles, nothing written.
      wr0 = wr_count;
      hold_cnt = 0;
      done_off = -1;
      start_load(32'h30, 6'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (Cpu_Hold) hold_cnt++;
         if (Done) done_off = cyc - start_cyc;
      end
      check("empty_hold_cycles", 32'(hold_cnt), 32'd2);
      check("empty_done_offset", 32'(done_off), 32'd2);
      check("empty_no_write", 32'(wr_count - wr0), 32'd0);

      // Overflow: the word at 124 fits, the one at 128 does not.
      wr0 = wr_count;
      exp_q.push_back({32'd124, 32'h0000_0013});
      start_load(32'd124, 6'd2);
      send_word(32'h0000_0013, 1'b0);
      send_word(32'h1111_1111, 1'b0);
      repeat (3) @(negedge clk);
      check("ovf_err", 32'(Err), 32'd1);
      check("ovf_hold", 32'(Cpu_Hold), 32'd1);
      check("ovf_busy", 32'(Busy), 32'd1);
      check("ovf_ready", 32'(Byte_Ready), 32'd0);
      check("ovf_state", 32'(dbg_state), 32'(ERR));
      check("ovf_writes", 32'(wr_count - wr0), 32'd1);
      start_load(32'h0, 6'd1);
      repeat (2) @(negedge clk);
      check("ovf_start_ignored", 32'(dbg_state), 32'(ERR));
      check("ovf_err_sticky", 32'(Err), 32'd1);
      do_reset();
      @(negedge clk);
      check("ovf_err_cleared", 32'(Err), 32'd0);
      check("ovf_hold_cleared", 32'(Cpu_Hold), 32'd0);

      // Reset after two bytes: partial word discarded, next load starts at byte 0.
      wr0 = wr_count;
      start_load(32'h10, 6'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_ready", 32'(Byte_Ready), 32'd0);
      check("midrst_no_write", 32'(wr_count - wr0), 32'd0);
      exp_q.push_back({32'h10, 32'h1122_3344});
      start_load(32'h10, 6'd1);
      send_word(32'h1122_3344, 1'b0);
      wait_done();
      check("midrst_reload_writes", 32'(wr_count - wr0), 32'd1);
      check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

      // Start pulsed during RECV with a different base/count must be ignored.
      wr0 = wr_count;
      exp_q.push_back({32'h20, 32'hCAFE_F00D});
      exp_q.push_back({32'h24, 32'h0BAD_BEEF});
      start_load(32'h20, 6'd2);
      send_byte(8'h0D);
      Start = 1'b1; Base_Addr = 32'h60; Num_Words = 6'd1;
      @(posedge clk); #1;
      Start = 1'b0;
      send_byte(8'hF0);
      send_byte(8'hFE);
      send_byte(8'hCA);
      send_word(32'h0BAD_BEEF, 1'b0);
      wait_done();
      check("busy_start_writes", 32'(wr_count - wr0), 32'd2);
      check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

      repeat (3) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
